// File: rtl/axi_aw_w_rr_arbiter_if.sv
// AW/W bus bundle between NUM_M masters and one slave port, plus arbiter status.
// The slave modport is the arbiter's view; the master modport is the surrounding environment.
interface axi_aw_w_rr_arbiter_if #(
  parameter int unsigned NUM_M    = 4,
  parameter int unsigned AWP_W    = 61,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned WQ_DEPTH = 4
);
  localparam int unsigned StrbW = DATA_W / 8;
  localparam int unsigned CntW  = $clog2(WQ_DEPTH + 1);
  localparam int unsigned IdxW  = $clog2(NUM_M);

  logic [NUM_M-1:0]        m_awvalid;
  logic [NUM_M-1:0]        m_awready;
  logic [NUM_M*AWP_W-1:0]  m_awpayload;
  logic                    s_awvalid;
  logic                    s_awready;
  logic [AWP_W-1:0]        s_awpayload;
  logic [NUM_M-1:0]        m_wvalid;
  logic [NUM_M-1:0]        m_wready;
  logic [NUM_M*DATA_W-1:0] m_wdata;
  logic [NUM_M*StrbW-1:0]  m_wstrb;
  logic [NUM_M-1:0]        m_wlast;
  logic                    s_wvalid;
  logic                    s_wready;
  logic [DATA_W-1:0]       s_wdata;
  logic [StrbW-1:0]        s_wstrb;
  logic                    s_wlast;
  logic [CntW-1:0]         wq_count;
  logic [IdxW-1:0]         last_grant;

  modport slave (
    input  m_awvalid, m_awpayload, s_awready, m_wvalid, m_wdata, m_wstrb, m_wlast, s_wready,
    output m_awready, s_awvalid, s_awpayload, m_wready, s_wvalid, s_wdata, s_wstrb, s_wlast,
    output wq_count, last_grant
  );

  modport master (
    output m_awvalid, m_awpayload, s_awready, m_wvalid, m_wdata, m_wstrb, m_wlast, s_wready,
    input  m_awready, s_awvalid, s_awpayload, m_wready, s_wvalid, s_wdata, s_wstrb, s_wlast,
    input  wq_count, last_grant
  );
endinterface

// File: rtl/axi_aw_w_rr_arbiter.sv
// Round-robin AW arbiter with a registered output stage; W beats follow AW grant order
// through a grant-index FIFO, each burst owning the W channel until its WLAST handshake.
module axi_aw_w_rr_arbiter #(
  parameter int unsigned NUM_M    = 4,
  parameter int unsigned AWP_W    = 61,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned WQ_DEPTH = 4
) (
  input logic                  ACLK,
  input logic                  ARESET,
  axi_aw_w_rr_arbiter_if.slave bus
);
  localparam int unsigned StrbW = DATA_W / 8;
  localparam int unsigned IdxW  = $clog2(NUM_M);
  localparam int unsigned CntW  = $clog2(WQ_DEPTH + 1);
  localparam int unsigned PtrW  = (WQ_DEPTH > 1) ? $clog2(WQ_DEPTH) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NUM_M - 1);
  localparam logic [CntW-1:0] FullCnt = CntW'(WQ_DEPTH);
  localparam logic [PtrW-1:0] LastPtr = PtrW'(WQ_DEPTH - 1);

  typedef enum logic [0:0] {StIdle, StBusy} aw_state_e;

  aw_state_e        state_q;
  logic [IdxW-1:0]  last_grant_q;
  logic             s_awvalid_q;
  logic [AWP_W-1:0] s_awpayload_q;
  logic [IdxW-1:0]  fifo_q [WQ_DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]  count_q;

  logic [AWP_W-1:0]  m_pay  [NUM_M];
  logic [DATA_W-1:0] m_data [NUM_M];
  logic [StrbW-1:0]  m_strb [NUM_M];

  logic            win_found, grant, push, pop, fifo_nempty;
  logic [IdxW-1:0] win_idx, head;

  for (genvar i = 0; i < NUM_M; i++) begin : g_unpack
    assign m_pay[i]  = bus.m_awpayload[i*AWP_W +: AWP_W];
    assign m_data[i] = bus.m_wdata[i*DATA_W +: DATA_W];
    assign m_strb[i] = bus.m_wstrb[i*StrbW +: StrbW];
  end

  // Search upward from the slot after the previous winner.
  always_comb begin
    int unsigned cand;
    cand      = 0;
    win_found = 1'b0;
    win_idx   = '0;
    for (int unsigned k = 1; k <= NUM_M; k++) begin
      cand = (32'(last_grant_q) + k) % NUM_M;
      if (!win_found && bus.m_awvalid[IdxW'(cand)]) begin
        win_found = 1'b1;
        win_idx   = IdxW'(cand);
      end
    end
  end

  assign grant       = (state_q == StIdle) && win_found && (count_q < FullCnt) && !ARESET;
  assign push        = (state_q == StBusy) && bus.s_awready;
  assign fifo_nempty = (count_q != '0);
  assign head        = fifo_q[rd_ptr_q];
  assign pop         = bus.s_wvalid && bus.s_wready && bus.s_wlast;

  always_comb begin
    bus.m_awready = '0;
    if (grant) bus.m_awready[win_idx] = 1'b1;
  end

  always_comb begin
    bus.m_wready = '0;
    bus.s_wvalid = 1'b0;
    bus.s_wdata  = '0;
    bus.s_wstrb  = '0;
    bus.s_wlast  = 1'b0;
    if (fifo_nempty) begin
      bus.s_wvalid       = bus.m_wvalid[head];
      bus.s_wdata        = m_data[head];
      bus.s_wstrb        = m_strb[head];
      bus.s_wlast        = bus.m_wlast[head];
      bus.m_wready[head] = bus.s_wready;
    end
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state_q       <= StIdle;
      last_grant_q  <= LastIdx;
      s_awvalid_q   <= 1'b0;
      s_awpayload_q <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (grant) begin
            last_grant_q  <= win_idx;
            s_awpayload_q <= m_pay[win_idx];
            s_awvalid_q   <= 1'b1;
            state_q       <= StBusy;
          end
        end
        StBusy: begin
          if (bus.s_awready) begin
            s_awvalid_q <= 1'b0;
            state_q     <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  always_ff @(posedge ACLK) begin
    if (push) fifo_q[wr_ptr_q] <= last_grant_q;
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= (wr_ptr_q == LastPtr) ? '0 : wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= (rd_ptr_q == LastPtr) ? '0 : rd_ptr_q + 1'b1;
      if (push && !pop)      count_q <= count_q + 1'b1;
      else if (pop && !push) count_q <= count_q - 1'b1;
    end
  end

  assign bus.s_awvalid   = s_awvalid_q;
  assign bus.s_awpayload = s_awpayload_q;
  assign bus.wq_count    = count_q;
  assign bus.last_grant  = last_grant_q;

  a_no_overflow: assert property (@(posedge ACLK) disable iff (ARESET)
    !(push && !pop && (count_q == FullCnt)));
  a_no_underflow: assert property (@(posedge ACLK) disable iff (ARESET)
    !(pop && (count_q == '0)));
endmodule

// File: tb/tb_axi_aw_w_rr_arbiter.sv
// Self-checking bench: vector table, directed corner sequences and random traffic,
// every cycle compared against a queue-based model of the arbiter's rules.
module tb_axi_aw_w_rr_arbiter;
  localparam int unsigned NUM_M    = 4;
  localparam int unsigned AWP_W    = 61;
  localparam int unsigned DATA_W   = 32;
  localparam int unsigned WQ_DEPTH = 4;
  localparam int unsigned StrbW    = DATA_W / 8;

  logic ACLK   = 1'b0;
  logic ARESET = 1'b1;
  always #5 ACLK = ~ACLK;

  axi_aw_w_rr_arbiter_if #(
    .NUM_M(NUM_M), .AWP_W(AWP_W), .DATA_W(DATA_W), .WQ_DEPTH(WQ_DEPTH)
  ) bus ();

  axi_aw_w_rr_arbiter #(
    .NUM_M(NUM_M), .AWP_W(AWP_W), .DATA_W(DATA_W), .WQ_DEPTH(WQ_DEPTH)
  ) dut (
    .ACLK  (ACLK),
    .ARESET(ARESET),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  logic [AWP_W-1:0]  pay [NUM_M];
  logic [DATA_W-1:0] wd  [NUM_M];
  logic [StrbW-1:0]  ws  [NUM_M];

  // Reference model: pending AW slot, previous winner, queue of granted master indices.
  int               m_last;
  bit               m_pend;
  int               m_pidx;
  logic [AWP_W-1:0] m_ppay;
  int               wq [$];

  int                e_grant;
  logic [NUM_M-1:0]  e_awrdy, e_wrdy;
  logic              e_sawv, e_swv, e_swlast;
  logic [DATA_W-1:0] e_wdata;
  logic [StrbW-1:0]  e_wstrb;

  typedef struct {
    logic [3:0] awv, wv, wl;
    logic       saw_rdy, sw_rdy;
    logic [3:0] e_awrdy, e_wrdy;
    logic       e_sawv, e_swv;
    int         e_wq, e_lg;
  } vec_t;

  vec_t vecs [$];

  function automatic vec_t mk(logic [3:0] awv, logic [3:0] wv, logic [3:0] wl, logic saw_rdy,
                              logic sw_rdy, logic [3:0] e_awrdy, logic [3:0] e_wrdy,
                              logic e_sawv, logic e_swv, int e_wq, int e_lg);
    vec_t v;
    v.awv = awv; v.wv = wv; v.wl = wl; v.saw_rdy = saw_rdy; v.sw_rdy = sw_rdy;
    v.e_awrdy = e_awrdy; v.e_wrdy = e_wrdy; v.e_sawv = e_sawv; v.e_swv = e_swv;
    v.e_wq = e_wq; v.e_lg = e_lg;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %h, expected %h", nm, $time, act, exp);
    end
  endtask

  task automatic pack();
    for (int i = 0; i < NUM_M; i++) begin
      bus.m_awpayload[i*AWP_W +: AWP_W] = pay[i];
      bus.m_wdata[i*DATA_W +: DATA_W]   = wd[i];
      bus.m_wstrb[i*StrbW +: StrbW]     = ws[i];
    end
  endtask

  task automatic model_reset();
    m_last = NUM_M - 1;
    m_pend = 0;
    m_pidx = 0;
    m_ppay = '0;
    wq.delete();
  endtask

  task automatic model_exp();
    int h;
    e_grant = -1; e_awrdy = '0; e_wrdy = '0; e_swv = 0; e_swlast = 0;
    e_wdata = '0; e_wstrb = '0;
    e_sawv  = m_pend;
    if (!ARESET && !m_pend && wq.size() < WQ_DEPTH)
      for (int k = 1; k <= NUM_M; k++) begin
        int j = (m_last + k) % NUM_M;
        if (e_grant < 0 && bus.m_awvalid[j]) e_grant = j;
      end
    if (e_grant >= 0) e_awrdy[e_grant] = 1'b1;
    if (wq.size() > 0) begin
      h         = wq[0];
      e_swv     = bus.m_wvalid[h];
      e_swlast  = bus.m_wlast[h];
      e_wdata   = wd[h];
      e_wstrb   = ws[h];
      e_wrdy[h] = bus.s_wready;
    end
  endtask

  task automatic model_upd();
    if (ARESET) begin
      model_reset();
      return;
    end
    if (e_swv && bus.s_wready && e_swlast) void'(wq.pop_front());
    if (m_pend) begin
      if (bus.s_awready) begin
        wq.push_back(m_pidx);
        m_pend = 0;
      end
    end else if (e_grant >= 0) begin
      m_pend = 1;
      m_pidx = e_grant;
      m_ppay = pay[e_grant];
      m_last = e_grant;
    end
  endtask

  task automatic sample();
    @(negedge ACLK);
    if (ARESET) model_reset();
    model_exp();
    chk("awready",     bus.m_awready,   e_awrdy);
    chk("wready",      bus.m_wready,    e_wrdy);
    chk("s_awvalid",   bus.s_awvalid,   e_sawv);
    chk("s_awpayload", bus.s_awpayload, m_ppay);
    chk("s_wvalid",    bus.s_wvalid,    e_swv);
    chk("s_wdata",     bus.s_wdata,     e_wdata);
    chk("s_wstrb",     bus.s_wstrb,     e_wstrb);
    chk("s_wlast",     bus.s_wlast,     e_swlast);
    chk("wq_count",    bus.wq_count,    wq.size());
    chk("last_grant",  bus.last_grant,  m_last);
  endtask

  task automatic advance();
    model_upd();
    @(posedge ACLK);
    #1;
  endtask

  task automatic tick();
    sample();
    advance();
  endtask

  task automatic idle_inputs();
    bus.m_awvalid = '0; bus.m_wvalid = '0; bus.m_wlast = '0;
    bus.s_awready = 1'b0; bus.s_wready = 1'b0;
  endtask

  task automatic do_reset();
    ARESET = 1'b1;
    idle_inputs();
    tick();
    tick();
    ARESET = 1'b0;
  endtask

  initial begin
    logic [AWP_W-1:0] held;
    for (int i = 0; i < NUM_M; i++) begin
      pay[i] = AWP_W'(64'h0A5A_0000_0000_1000 + 64'(i));
      wd[i]  = 32'hD000_0000 + 32'(i);
      ws[i]  = 4'(i + 1);
    end
    pack();
    model_reset();
    do_reset();

    // Rotation with all masters requesting, then a 4-beat burst from master 2.
    vecs.push_back(mk(4'hF, 4'hF, 4'hF, 1, 1, 4'b0001, 4'b0000, 0, 0, 0, 3));
    vecs.push_back(mk(4'hF, 4'hF, 4'hF, 1, 1, 4'b0000, 4'b0000, 1, 0, 0, 0));
    vecs.push_back(mk(4'hF, 4'hF, 4'hF, 1, 1, 4'b0010, 4'b0001, 0, 1, 1, 0));
    vecs.push_back(mk(4'hF, 4'hF, 4'hF, 1, 1, 4'b0000, 4'b0000, 1, 0, 0, 1));
    vecs.push_back(mk(4'hF, 4'hF, 4'hF, 1, 1, 4'b0100, 4'b0010, 0, 1, 1, 1));
    vecs.push_back(mk(4'hF, 4'hF, 4'hF, 1, 1, 4'b0000, 4'b0000, 1, 0, 0, 2));
    vecs.push_back(mk(4'hF, 4'hF, 4'hF, 1, 1, 4'b1000, 4'b0100, 0, 1, 1, 2));
    vecs.push_back(mk(4'hF, 4'hF, 4'hF, 1, 1, 4'b0000, 4'b0000, 1, 0, 0, 3));
    vecs.push_back(mk(4'hF, 4'hF, 4'hF, 1, 1, 4'b0001, 4'b1000, 0, 1, 1, 3));
    vecs.push_back(mk(4'hF, 4'hF, 4'hF, 1, 1, 4'b0000, 4'b0000, 1, 0, 0, 0));
    vecs.push_back(mk(4'h0, 4'hF, 4'hF, 1, 1, 4'b0000, 4'b0001, 0, 1, 1, 0));
    vecs.push_back(mk(4'h0, 4'h0, 4'h0, 1, 1, 4'b0000, 4'b0000, 0, 0, 0, 0));
    vecs.push_back(mk(4'h4, 4'h0, 4'h0, 1, 1, 4'b0100, 4'b0000, 0, 0, 0, 0));
    vecs.push_back(mk(4'h0, 4'h0, 4'h0, 1, 1, 4'b0000, 4'b0000, 1, 0, 0, 2));
    vecs.push_back(mk(4'h0, 4'h4, 4'h0, 1, 1, 4'b0000, 4'b0100, 0, 1, 1, 2));
    vecs.push_back(mk(4'h0, 4'h4, 4'h0, 1, 1, 4'b0000, 4'b0100, 0, 1, 1, 2));
    vecs.push_back(mk(4'h0, 4'h4, 4'h0, 1, 1, 4'b0000, 4'b0100, 0, 1, 1, 2));
    vecs.push_back(mk(4'h0, 4'h4, 4'h4, 1, 1, 4'b0000, 4'b0100, 0, 1, 1, 2));
    vecs.push_back(mk(4'h0, 4'h0, 4'h0, 1, 1, 4'b0000, 4'b0000, 0, 0, 0, 2));
    foreach (vecs[n]) begin
      bus.m_awvalid = vecs[n].awv; bus.m_wvalid = vecs[n].wv; bus.m_wlast = vecs[n].wl;
      bus.s_awready = vecs[n].saw_rdy; bus.s_wready = vecs[n].sw_rdy;
      sample();
      chk($sformatf("vec%0d_awready", n), bus.m_awready, vecs[n].e_awrdy);
      chk($sformatf("vec%0d_wready", n), bus.m_wready, vecs[n].e_wrdy);
      chk($sformatf("vec%0d_s_awvalid", n), bus.s_awvalid, vecs[n].e_sawv);
      chk($sformatf("vec%0d_s_wvalid", n), bus.s_wvalid, vecs[n].e_swv);
      chk($sformatf("vec%0d_wq_count", n), bus.wq_count, vecs[n].e_wq);
      chk($sformatf("vec%0d_last_grant", n), bus.last_grant, vecs[n].e_lg);
      advance();
    end

    // Slave stalls AW for 5 cycles while every master requests and payloads churn.
    do_reset();
    bus.m_awvalid = 4'b0010;
    tick();
    held = pay[1];
    bus.m_awvalid = 4'hF;
    for (int c = 0; c < 5; c++) begin
      for (int i = 0; i < NUM_M; i++) pay[i] = AWP_W'({$urandom, $urandom});
      pack();
      tick();
      chk("stall_s_awvalid", bus.s_awvalid, 1);
      chk("stall_payload", bus.s_awpayload, held);
      chk("stall_awready", bus.m_awready, 0);
    end
    bus.s_awready = 1'b1;
    bus.m_awvalid = '0;
    tick();

    // Master 1 presents W before its AW; master 3's burst goes first.
    do_reset();
    bus.s_awready = 1'b1; bus.s_wready = 1'b1;
    bus.m_awvalid = 4'b1000; bus.m_wvalid = 4'b0010; bus.m_wlast = 4'b0000;
    tick();
    chk("order_early_wready", bus.m_wready, 0);
    chk("order_early_s_wvalid", bus.s_wvalid, 0);
    bus.m_awvalid = 4'b0010; bus.m_wvalid = 4'b1010;
    tick();
    chk("order_m3_first", bus.m_wready, 4'b1000);
    chk("order_m3_data", bus.s_wdata, wd[3]);
    bus.m_wlast = 4'b1000;
    tick();
    chk("order_m1_waits", bus.m_wready, 0);
    bus.m_awvalid = 4'b0000; bus.m_wvalid = 4'b0010; bus.m_wlast = 4'b0010;
    tick();
    chk("order_m1_flows", bus.m_wready, 4'b0010);
    chk("order_m1_data", bus.s_wdata, wd[1]);
    tick();
    chk("order_drained", bus.wq_count, 0);

    // Fill the grant FIFO with W blocked, then free one slot.
    do_reset();
    bus.m_wvalid = 4'hF; bus.m_wlast = 4'hF;
    bus.m_awvalid = 4'hF; bus.s_awready = 1'b1;
    for (int c = 0; c < 8; c++) tick();
    chk("full_wq_count", bus.wq_count, 4);
    for (int c = 0; c < 2; c++) begin
      tick();
      chk("full_no_grant", bus.m_awready, 0);
      chk("full_no_awvalid", bus.s_awvalid, 0);
    end
    bus.s_wready = 1'b1;
    tick();
    chk("full_popped", bus.wq_count, 3);
    chk("full_grant_ready", bus.m_awready, 4'b0001);
    bus.s_wready = 1'b0;
    tick();
    chk("full_grant_taken", bus.s_awvalid, 1);
    chk("full_grant_index", bus.last_grant, 0);

    // Asynchronous reset while BUSY with two queued bursts.
    do_reset();
    bus.m_awvalid = 4'hF; bus.s_awready = 1'b1;
    bus.m_wvalid = 4'hF; bus.m_wlast = 4'hF;
    for (int c = 0; c < 5; c++) tick();
    chk("rst_pre_wq", bus.wq_count, 2);
    chk("rst_pre_busy", bus.s_awvalid, 1);
    bus.s_wready = 1'b1;
    ARESET = 1'b1;
    #1;
    chk("rst_s_awvalid", bus.s_awvalid, 0);
    chk("rst_wq_count", bus.wq_count, 0);
    chk("rst_awready", bus.m_awready, 0);
    chk("rst_wready", bus.m_wready, 0);
    chk("rst_last_grant", bus.last_grant, NUM_M - 1);
    tick();
    ARESET = 1'b0;
    idle_inputs();
    tick();

    // Random traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      ARESET = ($urandom_range(0, 599) == 0);
      bus.m_awvalid = 4'($urandom_range(0, 15));
      bus.m_wvalid  = 4'($urandom_range(0, 15));
      for (int i = 0; i < NUM_M; i++) begin
        bus.m_wlast[i] = ($urandom_range(0, 2) == 0);
        pay[i] = AWP_W'({$urandom, $urandom});
        wd[i]  = $urandom;
        ws[i]  = 4'($urandom_range(0, 15));
      end
      pack();
      bus.s_awready = ($urandom_range(0, 3) != 0);
      bus.s_wready  = ($urandom_range(0, 3) != 0);
      tick();
    end
    ARESET = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
